// File: rtl/fwd_hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module : fwd_hazard_scoreboard_if
// Brief  : ID-stage request / forwarding-response bundle between the decode
//          stage (master) and the forwarding/hazard unit (slave).
// Rev    : 1.0  initial release
// ============================================================================
interface fwd_hazard_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_AW  = 5,
  parameter int LAT_W   = 2,
  parameter int CNT_W   = 32,
  localparam int SEL_W  = $clog2(DEPTH + 1)
) ();
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rs_addr;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_we;
  logic [LAT_W-1:0]          id_lat;
  logic                      hold;
  logic                      flush;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
  logic                      issue;
  logic [CNT_W-1:0]          stall_count;

  modport master (
    output id_valid, id_rs_addr, id_rs_used, id_rd, id_we, id_lat, hold, flush,
    input  fwd_sel, stall, issue, stall_count
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rs_used, id_rd, id_we, id_lat, hold, flush,
    output fwd_sel, stall, issue, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : fwd_hazard_scoreboard
// Brief  : Shift-register scoreboard of in-flight register writes; produces
//          per-operand bypass selects, a hazard stall and a saturating
//          stall-cycle counter.
// Rev    : 1.0  initial release
// ============================================================================
module fwd_hazard_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_AW  = 5,
  parameter int LAT_W   = 2,
  parameter int CNT_W   = 32,
  localparam int SEL_W  = $clog2(DEPTH + 1)
) (
  input  wire logic clk,
  input  wire logic rst,
  fwd_hazard_scoreboard_if.slave bus
);

  // Scoreboard entries: index 0 is the instruction in EX, DEPTH-1 is in WB.
  logic              ent_v   [DEPTH];
  logic [REG_AW-1:0] ent_rd  [DEPTH];
  logic [LAT_W-1:0]  ent_lat [DEPTH];

  logic [NUM_SRC*SEL_W-1:0] sel;
  logic                     stall;
  logic                     issue;
  logic [LAT_W-1:0]         lat_in;
  logic [CNT_W-1:0]         stall_count;

  // Latencies beyond the last tracked stage behave as "ready in WB".
  always_comb begin
    lat_in = (int'(bus.id_lat) > DEPTH - 1) ? LAT_W'(DEPTH - 1) : bus.id_lat;
  end

  // Per-operand youngest-producer search; a younger unready match blocks older ones.
  always_comb begin
    logic [REG_AW-1:0] rs;
    logic              found;
    sel   = '0;
    stall = 1'b0;
    rs    = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rs    = bus.id_rs_addr[k*REG_AW +: REG_AW];
      found = 1'b0;
      if (bus.id_valid && bus.id_rs_used[k] && rs != '0) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!found && ent_v[i] && ent_rd[i] == rs) begin
            found = 1'b1;
            if (int'(ent_lat[i]) <= i) begin
              sel[k*SEL_W +: SEL_W] = SEL_W'(i + 1);
            end else begin
              stall = 1'b1;
            end
          end
        end
      end
    end
  end

  assign issue = bus.id_valid && !stall && !bus.hold && !bus.flush;

  // Advance the scoreboard unless frozen; a non-issuing cycle inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_v[i]   <= 1'b0;
        ent_rd[i]  <= '0;
        ent_lat[i] <= '0;
      end
    end else if (!bus.hold) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        ent_v[i]   <= ent_v[i-1];
        ent_rd[i]  <= ent_rd[i-1];
        ent_lat[i] <= ent_lat[i-1];
      end
      ent_v[0]   <= issue && bus.id_we && (bus.id_rd != '0);
      ent_rd[0]  <= issue ? bus.id_rd : '0;
      ent_lat[0] <= issue ? lat_in : '0;
    end
  end

  // Count cycles lost purely to data hazards; saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (bus.id_valid && stall && !bus.hold && !bus.flush &&
                 stall_count != {CNT_W{1'b1}}) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign bus.fwd_sel     = sel;
  assign bus.stall       = stall;
  assign bus.issue       = issue;
  assign bus.stall_count = stall_count;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : tb_fwd_hazard_scoreboard
// Brief  : Directed scoreboard bench; a 32-bit-counter instance and a 4-bit-
//          counter instance see identical stimulus.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_hazard_scoreboard_if #(.CNT_W(32)) bus_a ();
  fwd_hazard_scoreboard_if #(.CNT_W(4))  bus_b ();

  fwd_hazard_scoreboard #(.CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  fwd_hazard_scoreboard #(.CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic       id_valid = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, id_rd = '0;
  logic [1:0] used = '0, id_lat = '0;
  logic       id_we = 1'b0, hold = 1'b0, flush = 1'b0;

  assign bus_a.id_valid = id_valid;    assign bus_b.id_valid = id_valid;
  assign bus_a.id_rs_addr = {rs2, rs1}; assign bus_b.id_rs_addr = {rs2, rs1};
  assign bus_a.id_rs_used = used;      assign bus_b.id_rs_used = used;
  assign bus_a.id_rd = id_rd;          assign bus_b.id_rd = id_rd;
  assign bus_a.id_we = id_we;          assign bus_b.id_we = id_we;
  assign bus_a.id_lat = id_lat;        assign bus_b.id_lat = id_lat;
  assign bus_a.hold = hold;            assign bus_b.hold = hold;
  assign bus_a.flush = flush;          assign bus_b.flush = flush;

  typedef struct {
    string       name;
    logic [1:0]  sel0;
    logic [1:0]  sel1;
    logic        stall;
    logic        issue;
    logic        chk_cnt;
    logic [31:0] cnt;
    logic        chk_cnt_s;
    logic [3:0]  cnt_s;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: outputs are combinational, compare mid-cycle after stimulus settles.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".sel0"},  32'(bus_a.fwd_sel[1:0]), 32'(e.sel0));
      chk({e.name, ".sel1"},  32'(bus_a.fwd_sel[3:2]), 32'(e.sel1));
      chk({e.name, ".stall"}, 32'(bus_a.stall), 32'(e.stall));
      chk({e.name, ".issue"}, 32'(bus_a.issue), 32'(e.issue));
      if (e.chk_cnt)   chk({e.name, ".cnt"},   bus_a.stall_count, e.cnt);
      if (e.chk_cnt_s) chk({e.name, ".cnt4"},  32'(bus_b.stall_count), 32'(e.cnt_s));
    end
  end

  // Drive one ID cycle just after the rising edge.
  task automatic cyc(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [1:0] u, input logic [4:0] rd, input logic we,
                     input logic [1:0] lat, input logic h, input logic f);
    @(posedge clk); #1;
    id_valid = v; rs1 = a1; rs2 = a2; used = u;
    id_rd = rd; id_we = we; id_lat = lat; hold = h; flush = f;
  endtask

  task automatic expect_out(input string n, input logic [1:0] s0, input logic [1:0] s1,
                            input logic st, input logic is, input logic cc,
                            input logic [31:0] c, input logic ccs, input logic [3:0] cs);
    exp_t e;
    e.name = n; e.sel0 = s0; e.sel1 = s1; e.stall = st; e.issue = is;
    e.chk_cnt = cc; e.cnt = c; e.chk_cnt_s = ccs; e.cnt_s = cs;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset with a live reader present.
    cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
    cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
    rst = 1'b0;
    expect_out("reset", 0, 0, 0, 1, 1, 0, 1, 0);

    // ALU chain on x5.
    cyc(1, 0, 0, 2'b00, 5, 1, 0, 0, 0); expect_out("alu_issue", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("alu_e0", 1, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("alu_e1", 2, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("alu_e2", 3, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("alu_rf", 0, 0, 0, 1, 0, 0, 0, 0);

    // Load-use on x6 through operand 1.
    cyc(1, 0, 0, 2'b00, 6, 1, 1, 0, 0); expect_out("ld_issue", 0, 0, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 6, 2'b10, 0, 0, 0, 0, 0); expect_out("ld_use", 0, 0, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 6, 2'b10, 0, 0, 0, 0, 0); expect_out("ld_fwd", 0, 2, 0, 1, 1, 1, 0, 0);

    // Youngest producer of x7 wins; x0 is never tracked.
    cyc(1, 0, 0, 2'b00, 7, 1, 0, 0, 0); expect_out("x7_a", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 2'b00, 7, 1, 0, 0, 0); expect_out("x7_b", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 7, 7, 2'b11, 0, 0, 0, 0, 0); expect_out("x7_young", 1, 1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 2'b00, 0, 1, 0, 0, 0); expect_out("x0_wr", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 2'b11, 0, 0, 0, 0, 0); expect_out("x0_rd", 0, 0, 0, 1, 0, 0, 0, 0);

    // Younger unready x10 (lat 2) shadows older ready x10: 2 stall cycles.
    cyc(1, 0, 0, 2'b00, 10, 1, 0, 0, 0); expect_out("x10_old", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 2'b00, 10, 1, 2, 0, 0); expect_out("x10_new", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 10, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("x10_st1", 0, 0, 1, 0, 1, 1, 0, 0);
    cyc(1, 10, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("x10_st2", 0, 0, 1, 0, 1, 2, 0, 0);
    cyc(1, 10, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("x10_fwd", 3, 0, 0, 1, 1, 3, 0, 0);

    // Hold freezes x8 in entry 0; counter untouched.
    cyc(1, 0, 0, 2'b00, 8, 1, 0, 0, 0); expect_out("x8_issue", 0, 0, 0, 1, 0, 0, 0, 0);
    for (int h = 0; h < 3; h++) begin
      cyc(1, 8, 0, 2'b01, 0, 0, 0, 1, 0); expect_out("hold", 1, 0, 0, 0, 1, 3, 0, 0);
    end
    cyc(1, 8, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("hold_end", 1, 0, 0, 1, 1, 3, 0, 0);

    // Flushed writer of x9 is never tracked.
    cyc(1, 0, 0, 2'b00, 9, 1, 0, 0, 1); expect_out("x9_flush", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 9, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("x9_rd1", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 9, 2'b10, 0, 0, 0, 0, 0); expect_out("x9_rd2", 0, 0, 0, 1, 0, 0, 0, 0);

    // Stall together with flush: no count, bubble inserted.
    cyc(1, 0, 0, 2'b00, 11, 1, 1, 0, 0); expect_out("x11_issue", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 11, 0, 2'b01, 0, 0, 0, 0, 1); expect_out("stall_flush", 0, 0, 1, 0, 1, 3, 0, 0);
    cyc(1, 11, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("after_sf", 2, 0, 0, 1, 1, 3, 0, 0);

    // id_lat 3 clamps to 2.
    cyc(1, 0, 0, 2'b00, 12, 1, 3, 0, 0); expect_out("x12_issue", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 12, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("clamp_st1", 0, 0, 1, 0, 1, 3, 0, 0);
    cyc(1, 12, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("clamp_st2", 0, 0, 1, 0, 1, 4, 0, 0);
    cyc(1, 12, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("clamp_fwd", 3, 0, 0, 1, 1, 5, 1, 5);

    // 20 load-use stalls: 32-bit counter reaches 25, 4-bit counter saturates.
    for (int n = 0; n < 20; n++) begin
      cyc(1, 0, 0, 2'b00, 13, 1, 1, 0, 0); expect_out("sat_ld", 0, 0, 0, 1, 0, 0, 0, 0);
      cyc(1, 13, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("sat_use", 0, 0, 1, 0, 0, 0, 0, 0);
      cyc(1, 13, 0, 2'b01, 0, 0, 0, 0, 0); expect_out("sat_fwd", 2, 0, 0, 1, 0, 0, 0, 0);
    end
    cyc(1, 0, 0, 2'b00, 0, 0, 0, 0, 0); expect_out("sat_end", 0, 0, 0, 1, 1, 25, 1, 15);

    // Mid-operation reset discards in-flight x14.
    cyc(1, 0, 0, 2'b00, 14, 1, 1, 0, 0); expect_out("x14_issue", 0, 0, 0, 1, 0, 0, 0, 0);
    @(posedge clk); #1; rst = 1'b1;
    id_valid = 1'b1; rs1 = 14; used = 2'b01; id_we = 1'b0; id_rd = 0;
    cyc(1, 14, 0, 2'b01, 0, 0, 0, 0, 0);
    rst = 1'b0;
    expect_out("rst_mid", 0, 0, 0, 1, 1, 0, 1, 0);

    @(posedge clk); #1;
    id_valid = 1'b0;
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against any stall of the stimulus thread.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_scoreboard.md
# fwd_hazard_scoreboard

Parametrised forwarding and hazard unit for the in-order pipeline. It tracks in-flight register writes in a shift-register scoreboard, one entry per post-ID stage. For every ID source operand it computes a bypass select, or a stall when the producing result is not yet available (load-use and other multi-stage latencies). It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- NUM_SRC, 2: source operands per instruction.
- DEPTH, 3: tracked stages after ID (entry 0 = EX, entry DEPTH-1 = WB).
- REG_AW, 5: register address width.
- LAT_W, 2: width of the result-latency field.
- CNT_W, 32: stall counter width.
- SEL_W, derived = clog2(DEPTH+1): per-operand select width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  valid instruction in ID.
- id_rs_addr  in  NUM_SRC*REG_AW  source addresses; operand k occupies bits [k*REG_AW +: REG_AW].
- id_rs_used  in  NUM_SRC  operand k is actually read.
- id_rd  in  REG_AW  destination register.
- id_we  in  1  instruction writes id_rd.
- id_lat  in  LAT_W  first entry index at which the result is forwardable (0 = ALU, 1 = load, ...).
- hold  in  1  global pipeline freeze (e.g. memory wait).
- flush  in  1  squash the ID instruction (taken branch/jump).
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file; i+1 = result of entry i.
- stall  out  1  ID must not advance; inserts a bubble into EX.
- issue  out  1  id_valid & !stall & !hold & !flush.
- stall_count  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Each entry holds {v, rd, lat}.
  - v is set only for a writing instruction with rd != 0.
  - lat is clamped to DEPTH-1 on load.
- When !hold, the scoreboard shifts every cycle:
  - entry[i+1] <= entry[i];
  - entry 0 <= issue ? {id_we && id_rd != 0, id_rd, min(id_lat, DEPTH-1)} : empty.
  - Entry DEPTH-1 drops out; its write is in the register file from the next cycle.
- When hold: all entries keep their value. flush has no scoreboard effect beyond suppressing issue.
- Per operand k, evaluated only if id_valid and id_rs_used[k] and rs != 0:
  - Find the lowest index i with entry[i].v and entry[i].rd == rs (the youngest producer wins).
  - If there is no match: sel = 0.
  - If a match exists and i >= entry[i].lat: sel = i+1, no hazard.
  - If a match exists and i < entry[i].lat: hazard; sel = 0 (don't care).
- Unused operands and x0 operands: sel = 0, never hazard.
- stall = OR of operand hazards. It is combinational and is asserted regardless of hold.
- An older matching entry never overrides a younger one, even if the younger one is not ready.
- stall_count increments when id_valid & stall & !hold & !flush, and saturates at all-ones.

## Timing
- fwd_sel, stall and issue are combinational from the inputs and the current scoreboard. There is no added latency.
- Scoreboard and counter update on the rising clk edge.
- Reset (rst high at an edge):
  - all entries are invalid and stall_count = 0;
  - consequently fwd_sel = 0 and stall = 0 in the following cycle for any input.
- Reset mid-operation discards all in-flight tracking; no partial state survives.
- Load-use (lat 1, DEPTH 3):
  - the consumer directly behind the load stalls for exactly 1 cycle;
  - the next cycle it sees sel = 2.
- A producer with lat = L causes a consumer directly behind it to stall for L cycles, then forward from entry L.
- Simultaneous stall and flush: issue = 0, a bubble enters, and the counter does not increment.
- Simultaneous hold and flush: the scoreboard is frozen and issue = 0.
- id_lat > DEPTH-1 behaves exactly as DEPTH-1.

## Test plan
All scenarios use DEPTH=3, NUM_SRC=2.
- Reset: assert rst for 1 cycle with id_valid=1, rs1=x5 -> fwd_sel=0, stall=0, stall_count=0.
- ALU chain: issue x5 (lat 0); next cycle read rs1=x5 -> fwd_sel[0]=1, stall=0. Two cycles later with no newer writer -> sel=2, then sel=3, then 0.
- Load-use: issue x6 (lat 1); next cycle read rs2=x6 -> stall=1, issue=0, stall_count=1. Following cycle -> stall=0, fwd_sel[1]=2.
- Youngest priority and x0:
  - x7 is written by two consecutive instructions; read x7 -> sel=1, not 2.
  - Write x0, then read x0 -> sel=0, no stall.
- Hold/flush:
  - With x8 in entry 0, hold for 3 cycles -> sel stays 1 and stall_count is unchanged.
  - Then flush an ID writer of x9 -> x9 is never matched afterwards.
- Saturation: preload stall_count near max via a CNT_W=4 build; 20 load-use stalls -> stall_count=15.
